// File: rtl/fixed_round_scheduler_pkg.sv
// Shared types and sizing helpers for the time-multiplexed rounding scheduler.
package fixed_round_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        OUT  = 2'd2
    } state_e;

    function automatic int calc_beats(input int in_size, input int par);
        return in_size / par;
    endfunction

    // A single-beat schedule still needs a 1-bit counter to keep the datapath legal.
    function automatic int calc_cnt_width(input int in_size, input int par);
        int beats;
        beats = calc_beats(in_size, par);
        if (beats <= 1) begin
            return 1;
        end else begin
            return $clog2(beats);
        end
    endfunction

endpackage

// File: rtl/fixed_round_scheduler_if.sv
// Producer/consumer valid-ready bundle seen by the rounding scheduler.
interface fixed_round_scheduler_if #(
    parameter int IN_SIZE   = 8,
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 3
);
    logic signed [IN_WIDTH-1:0]  data_in [IN_SIZE];
    logic                        data_in_valid;
    logic                        data_in_ready;
    logic signed [OUT_WIDTH-1:0] data_out [IN_SIZE];
    logic                        data_out_valid;
    logic                        data_out_ready;

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/fixed_round_scheduler_rounding.sv
// Combinational bank of fixed-point rounders: round half toward +inf, then saturate.
module fixed_rounding #(
    parameter int IN_SIZE        = 2,
    parameter int IN_WIDTH       = 8,
    parameter int IN_FRAC_WIDTH  = 3,
    parameter int OUT_WIDTH      = 3,
    parameter int OUT_FRAC_WIDTH = 1
) (
    input  logic signed [IN_WIDTH-1:0]  data_in_i  [IN_SIZE],
    output logic signed [OUT_WIDTH-1:0] data_out_o [IN_SIZE]
);
    localparam int SHIFT = IN_FRAC_WIDTH - OUT_FRAC_WIDTH;
    localparam int RSH   = (SHIFT > 0) ? SHIFT : 0;
    localparam int LSH   = (SHIFT > 0) ? 0 : -SHIFT;
    localparam int WIDE  = ((IN_WIDTH + LSH) > OUT_WIDTH) ? (IN_WIDTH + LSH) : OUT_WIDTH;
    localparam int EW    = WIDE + 2;

    localparam logic signed [EW-1:0] HALF_C =
        (RSH > 0) ? EW'(32'sd1 <<< (RSH - 1)) : '0;
    localparam logic signed [EW-1:0] OMAX_C = EW'((32'sd1 <<< (OUT_WIDTH - 1)) - 32'sd1);
    localparam logic signed [EW-1:0] OMIN_C = EW'(-(32'sd1 <<< (OUT_WIDTH - 1)));

    function automatic logic signed [OUT_WIDTH-1:0] round_elem(
        input logic signed [IN_WIDTH-1:0] x
    );
        logic signed [EW-1:0] v;
        v = {{(EW - IN_WIDTH){x[IN_WIDTH-1]}}, x};
        v = (v <<< LSH) + HALF_C;
        v = v >>> RSH;
        if (v > OMAX_C) begin
            return OMAX_C[OUT_WIDTH-1:0];
        end else if (v < OMIN_C) begin
            return OMIN_C[OUT_WIDTH-1:0];
        end else begin
            return v[OUT_WIDTH-1:0];
        end
    endfunction

    // Every lane rounds independently.
    always_comb begin
        for (int k = 0; k < IN_SIZE; k++) begin
            data_out_o[k] = round_elem(data_in_i[k]);
        end
    end

endmodule

// File: rtl/fixed_round_scheduler.sv
// Rounds a latched IN_SIZE vector through PARALLELISM shared lanes over BEATS cycles.
module fixed_round_scheduler
    import fixed_round_scheduler_pkg::*;
#(
    parameter int IN_SIZE        = 8,
    parameter int PARALLELISM    = 2,
    parameter int IN_WIDTH       = 8,
    parameter int IN_FRAC_WIDTH  = 3,
    parameter int OUT_WIDTH      = 3,
    parameter int OUT_FRAC_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    fixed_round_scheduler_if.slave bus,
    output logic                   busy
);
    localparam int BEATS = calc_beats(IN_SIZE, PARALLELISM);
    localparam int CW    = calc_cnt_width(IN_SIZE, PARALLELISM);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if ((IN_SIZE % PARALLELISM) != 0) begin : g_bad_parallelism
        $error("IN_SIZE must be a multiple of PARALLELISM");
    end

    state_e                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic signed [IN_WIDTH-1:0]  in_buf_q  [IN_SIZE];
    logic signed [IN_WIDTH-1:0]  in_buf_d  [IN_SIZE];
    logic signed [OUT_WIDTH-1:0] out_buf_q [IN_SIZE];
    logic signed [OUT_WIDTH-1:0] out_buf_d [IN_SIZE];
    logic signed [IN_WIDTH-1:0]  lane_in_s  [PARALLELISM];
    logic signed [OUT_WIDTH-1:0] lane_out_s [PARALLELISM];
    logic                        load_s, wr_en_s;
    logic                        in_ready_q, out_valid_q, busy_q;
    int                          base_s;

    fixed_rounding #(
        .IN_SIZE       (PARALLELISM),
        .IN_WIDTH      (IN_WIDTH),
        .IN_FRAC_WIDTH (IN_FRAC_WIDTH),
        .OUT_WIDTH     (OUT_WIDTH),
        .OUT_FRAC_WIDTH(OUT_FRAC_WIDTH)
    ) u_lanes (
        .data_in_i (lane_in_s),
        .data_out_o(lane_out_s)
    );

    // Next-state logic: accept in IDLE, walk the beats in PROC, hold in OUT until taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        wr_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.data_in_valid && in_ready_q) begin
                    load_s  = 1'b1;
                    cnt_d   = '0;
                    state_d = PROC;
                end else begin
                    state_d = IDLE;
                end
            end
            PROC: begin
                wr_en_s = 1'b1;
                if (cnt_q == LAST_BEAT) begin
                    cnt_d   = '0;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            OUT: begin
                if (bus.data_out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Slice select into the lanes and scatter of lane results back into the output buffer.
    always_comb begin
        base_s = int'(cnt_q) * PARALLELISM;
        for (int j = 0; j < PARALLELISM; j++) begin
            lane_in_s[j] = '0;
            for (int k = 0; k < IN_SIZE; k++) begin
                if (k == base_s + j) begin
                    lane_in_s[j] = in_buf_q[k];
                end else begin
                    lane_in_s[j] = lane_in_s[j];
                end
            end
        end
        out_buf_d = out_buf_q;
        for (int k = 0; k < IN_SIZE; k++) begin
            for (int j = 0; j < PARALLELISM; j++) begin
                if (wr_en_s && (k == base_s + j)) begin
                    out_buf_d[k] = lane_out_s[j];
                end else begin
                    out_buf_d[k] = out_buf_d[k];
                end
            end
        end
        if (load_s) begin
            in_buf_d = bus.data_in;
        end else begin
            in_buf_d = in_buf_q;
        end
    end

    // State, buffers and flags; flags decode the next state so outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < IN_SIZE; k++) begin
                in_buf_q[k]  <= '0;
                out_buf_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_buf_q    <= in_buf_d;
            out_buf_q   <= out_buf_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == OUT);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign bus.data_in_ready  = in_ready_q;
    assign bus.data_out_valid = out_valid_q;
    assign bus.data_out       = out_buf_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_fixed_round_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a real-arithmetic model.
module tb_fixed_round_scheduler;
    localparam int N  = 8;
    localparam int IW = 8;
    localparam int OW = 3;
    localparam int IFW = 3;
    localparam int OFW = 1;
    localparam int LIMIT = 60000;

    localparam logic [63:0] DIR_IN  = {8'hFC, 8'h00, 8'h02, 8'hFD, 8'hC0, 8'h40, 8'h0C, 8'h05};
    localparam logic [23:0] DIR_EXP = {3'b111, 3'b000, 3'b001, 3'b111, 3'b100, 3'b011, 3'b011, 3'b001};

    logic clk = 1'b0;
    logic rst;
    logic busy, busy8;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fixed_round_scheduler_if #(.IN_SIZE(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();
    fixed_round_scheduler_if #(.IN_SIZE(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus8 ();

    fixed_round_scheduler #(
        .IN_SIZE(N), .PARALLELISM(2), .IN_WIDTH(IW), .IN_FRAC_WIDTH(IFW),
        .OUT_WIDTH(OW), .OUT_FRAC_WIDTH(OFW)
    ) dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));

    fixed_round_scheduler #(
        .IN_SIZE(N), .PARALLELISM(8), .IN_WIDTH(IW), .IN_FRAC_WIDTH(IFW),
        .OUT_WIDTH(OW), .OUT_FRAC_WIDTH(OFW)
    ) dut8 (.clk(clk), .rst(rst), .bus(bus8), .busy(busy8));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: scale to the output grid in real arithmetic, round half up, clamp.
    function automatic logic [2:0] ref_elem(input logic [7:0] x);
        real r;
        int  y;
        r = $itor($signed(x)) * (2.0 ** OFW) / (2.0 ** IFW);
        y = int'($floor(r + 0.5));
        if (y > (2 ** (OW - 1)) - 1) y = (2 ** (OW - 1)) - 1;
        if (y < -(2 ** (OW - 1)))    y = -(2 ** (OW - 1));
        return y[2:0];
    endfunction

    function automatic logic [23:0] ref_vec(input logic [63:0] v);
        logic [23:0] r;
        for (int k = 0; k < N; k++) r[k*3 +: 3] = ref_elem(v[k*8 +: 8]);
        return r;
    endfunction

    function automatic logic [23:0] pack_out();
        logic [23:0] p;
        for (int k = 0; k < N; k++) p[k*3 +: 3] = bus.data_out[k];
        return p;
    endfunction

    function automatic logic [23:0] pack_out8();
        logic [23:0] p;
        for (int k = 0; k < N; k++) p[k*3 +: 3] = bus8.data_out[k];
        return p;
    endfunction

    function automatic logic [63:0] pack_in();
        logic [63:0] p;
        for (int k = 0; k < N; k++) p[k*8 +: 8] = bus.data_in[k];
        return p;
    endfunction

    task automatic set_din(input logic [63:0] v);
        for (int k = 0; k < N; k++) begin
            bus.data_in[k]  = v[k*8 +: 8];
            bus8.data_in[k] = v[k*8 +: 8];
        end
    endtask

    // Present v until accepted; returns positioned at the first cycle after the handshake.
    task automatic send_one(input logic [63:0] v);
        int n;
        set_din(v);
        bus.data_in_valid = 1'b1;
        n = 0;
        while (!bus.data_in_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("send_ready", bus.data_in_ready, 1'b1);
        tick();
        bus.data_in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.data_out_valid && n < 50) begin
            tick();
            n++;
        end
        check_eq("wait_valid", bus.data_out_valid, 1'b1);
    endtask

    task automatic run_traffic(input int n_vec, input bit rnd, input bit chk_gap);
        logic [23:0] exp_q[$];
        logic [23:0] pend_data;
        bit          pend_valid;
        bit          hs_in;
        int          accepted, cyc, last_hs;
        accepted = 0; cyc = 0; last_hs = -1; pend_valid = 1'b0; pend_data = '0;
        while ((accepted < n_vec || exp_q.size() != 0) && cyc < LIMIT) begin
            if (pend_valid) begin
                check_eq("hold_valid", bus.data_out_valid, 1'b1);
                check_eq("hold_data", pack_out(), pend_data);
            end
            if (exp_q.size() == 0) check_eq("sb_no_extra", bus.data_out_valid, 1'b0);
            set_din({$urandom, $urandom});
            bus.data_in_valid  = (accepted < n_vec) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.data_out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            pend_valid = 1'b0;
            if (bus.data_out_valid && exp_q.size() != 0) begin
                if (bus.data_out_ready) begin
                    check_eq("sb_data", pack_out(), exp_q.pop_front());
                end else begin
                    pend_valid = 1'b1;
                    pend_data  = exp_q[0];
                end
            end
            hs_in = bus.data_in_valid && bus.data_in_ready;
            if (hs_in) begin
                exp_q.push_back(ref_vec(pack_in()));
                accepted++;
                if (chk_gap && last_hs >= 0) check_eq("b2b_gap", cyc - last_hs, 6);
                last_hs = cyc;
            end
            tick();
            cyc++;
        end
        check_eq("traffic_done", (n_vec - accepted) + exp_q.size(), 0);
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 1'b1;
    endtask

    initial begin
        logic [63:0] v1, v2;
        logic [23:0] got, got8;
        int          first, first8;

        rst = 1'b1;
        set_din('0);
        bus.data_in_valid = 1'b0;  bus.data_out_ready = 1'b0;
        bus8.data_in_valid = 1'b0; bus8.data_out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_ready", bus.data_in_ready, 1'b1);
        check_eq("rst_valid", bus.data_out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_data", pack_out(), 24'd0);
        check_eq("rst8_ready", bus8.data_in_ready, 1'b1);

        // Directed vector on both the 2-lane and 8-lane instances.
        set_din(DIR_IN);
        bus.data_in_valid = 1'b1;  bus8.data_in_valid = 1'b1;
        bus.data_out_ready = 1'b1; bus8.data_out_ready = 1'b1;
        tick();
        bus.data_in_valid = 1'b0;  bus8.data_in_valid = 1'b0;
        first = -1; first8 = -1; got = '0; got8 = '0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= 5) check_eq("s1_ready_low", bus.data_in_ready, 1'b0);
            if (c <= 4) check_eq("s1_busy", busy, 1'b1);
            if (bus.data_out_valid && first < 0) begin first = c; got = pack_out(); end
            if (bus8.data_out_valid && first8 < 0) begin first8 = c; got8 = pack_out8(); end
            tick();
        end
        check_eq("s1_latency", first, 5);
        check_eq("s1_data", got, DIR_EXP);
        check_eq("p8_latency", first8, 2);
        check_eq("p8_data", got8, DIR_EXP);

        // Backpressure: output held for 10 cycles while a second vector waits.
        v1 = {$urandom, $urandom};
        v2 = {$urandom, $urandom};
        bus.data_out_ready = 1'b0;
        send_one(v1);
        wait_valid();
        set_din(v2);
        bus.data_in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            check_eq("bp_valid", bus.data_out_valid, 1'b1);
            check_eq("bp_data", pack_out(), ref_vec(v1));
            check_eq("bp_ready", bus.data_in_ready, 1'b0);
            tick();
        end
        bus.data_out_ready = 1'b1;
        check_eq("bp_ready_hs", bus.data_in_ready, 1'b0);
        tick();
        check_eq("bp_idle_ready", bus.data_in_ready, 1'b1);
        check_eq("bp_idle_valid", bus.data_out_valid, 1'b0);
        check_eq("bp_hold_data", pack_out(), ref_vec(v1));
        tick();
        bus.data_in_valid = 1'b0;
        check_eq("bp_v2_taken", bus.data_in_ready, 1'b0);
        wait_valid();
        check_eq("bp_v2_data", pack_out(), ref_vec(v2));
        tick();

        // Reset on the third PROC cycle discards the vector.
        send_one(DIR_IN);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mr_valid", bus.data_out_valid, 1'b0);
        check_eq("mr_data", pack_out(), 24'd0);
        check_eq("mr_ready", bus.data_in_ready, 1'b1);
        check_eq("mr_busy", busy, 1'b0);
        v1 = {$urandom, $urandom};
        send_one(v1);
        wait_valid();
        check_eq("mr_next_data", pack_out(), ref_vec(v1));
        tick();

        run_traffic(6, 1'b0, 1'b1);
        run_traffic(1000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
